// File: rtl/mux_id_arbiter_pkg.sv
// Shared definitions for the ID-routing arbiters: default master count and
// the select-width helper used to size select ports.
package mux_id_arbiter_pkg;

    localparam int DEFAULT_NUM_MASTERS = 4;

    // A select port is never narrower than one bit, even for a single choice.
    function automatic int sel_width(input int num_masters);
        int w;
        w = $clog2(num_masters);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_id_arbiter_segment_mux.sv
// Combinational selection of one NUM_MASTERS-wide segment out of a flattened
// ID vector, with an out-of-range flag for non-power-of-two master counts.
module id_segment_mux
    import mux_id_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    localparam int SEL_W = sel_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS*NUM_MASTERS-1:0] id_vector,
    input  logic [SEL_W-1:0]                   number_select,
    output logic [NUM_MASTERS-1:0]             id_selected,
    output logic                               select_err
);

    // Only the matching segment is ever read, so X on other segments cannot leak.
    always_comb begin
        id_selected = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (int'(number_select) == k) begin
                id_selected = id_vector[k*NUM_MASTERS +: NUM_MASTERS];
            end
        end
    end

    assign select_err = (int'(number_select) >= NUM_MASTERS);

endmodule

// File: rtl/mux_id_arbiter.sv
// ID segment router: combinational select path plus a one-cycle registered
// copy and a change-detect pulse on the registered value.
module mux_id_arbiter
    import mux_id_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    localparam int SEL_W = sel_width(NUM_MASTERS)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NUM_MASTERS*NUM_MASTERS-1:0] Master_ID_Selected_i,
    input  logic [SEL_W-1:0]                   number_select_i,
    output logic [NUM_MASTERS-1:0]             Master_ID_Selected_o,
    output logic [NUM_MASTERS-1:0]             Master_ID_Selected_r_o,
    output logic                               select_err_o,
    output logic                               select_err_r_o,
    output logic                               sel_changed_o
);

    logic [NUM_MASTERS-1:0] id_sel;
    logic                   sel_err;

    id_segment_mux #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_segment_mux (
        .id_vector     (Master_ID_Selected_i),
        .number_select (number_select_i),
        .id_selected   (id_sel),
        .select_err    (sel_err)
    );

    assign Master_ID_Selected_o = id_sel;
    assign select_err_o         = sel_err;

    // Change is judged against the previously held value, so the first load
    // after reset pulses whenever the captured segment is nonzero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            Master_ID_Selected_r_o <= '0;
            select_err_r_o         <= 1'b0;
            sel_changed_o          <= 1'b0;
        end else begin
            Master_ID_Selected_r_o <= id_sel;
            select_err_r_o         <= sel_err;
            sel_changed_o          <= (id_sel != Master_ID_Selected_r_o);
        end
    end

endmodule

// File: tb/tb_mux_id_arbiter.sv
// Directed bench for mux_id_arbiter with a 4-master and a 3-master instance.
module tb_mux_id_arbiter;

    logic        clk;
    logic        rst;

    logic [15:0] ids4;
    logic [1:0]  sel4;
    logic [3:0]  out4, out4_r;
    logic        err4, err4_r, chg4;

    logic [8:0]  ids3;
    logic [1:0]  sel3;
    logic [2:0]  out3, out3_r;
    logic        err3, err3_r, chg3;

    logic [4:0]  sel_wide;
    logic [3:0]  exp4 [4];

    int checks   = 0;
    int failures = 0;

    mux_id_arbiter #(.NUM_MASTERS(4)) dut4 (
        .clk_i                  (clk),
        .reset_i                (rst),
        .Master_ID_Selected_i   (ids4),
        .number_select_i        (sel4),
        .Master_ID_Selected_o   (out4),
        .Master_ID_Selected_r_o (out4_r),
        .select_err_o           (err4),
        .select_err_r_o         (err4_r),
        .sel_changed_o          (chg4)
    );

    mux_id_arbiter #(.NUM_MASTERS(3)) dut3 (
        .clk_i                  (clk),
        .reset_i                (rst),
        .Master_ID_Selected_i   (ids3),
        .number_select_i        (sel3),
        .Master_ID_Selected_o   (out3),
        .Master_ID_Selected_r_o (out3_r),
        .select_err_o           (err3),
        .select_err_r_o         (err3_r),
        .sel_changed_o          (chg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        ids4 = 16'hDCBA;
        sel4 = 2'd0;
        ids3 = 9'b101_011_110;
        sel3 = 2'd0;
        exp4[0] = 4'b1010;
        exp4[1] = 4'b1011;
        exp4[2] = 4'b1100;
        exp4[3] = 4'b1101;
        #1;
        check("rst_r4",   32'(out4_r), 32'h0);
        check("rst_err4", 32'(err4_r), 32'h0);
        check("rst_chg4", 32'(chg4),   32'h0);
        check("rst_comb4", 32'(out4),  32'hA);

        // combinational path works while reset is held
        for (int k = 0; k < 4; k++) begin
            sel4 = 2'(k);
            #1;
            check($sformatf("comb4_sel%0d", k), 32'(out4), 32'(exp4[k]));
            check($sformatf("err4_sel%0d", k),  32'(err4), 32'h0);
        end

        sel_wide = 5'd16;
        sel4 = 2'(sel_wide);
        #1;
        check("trunc16_out", 32'(out4), 32'hA);
        check("trunc16_err", 32'(err4), 32'h0);

        sel3 = 2'd0; #1; check("comb3_sel0", 32'(out3), 32'b110);
        sel3 = 2'd1; #1; check("comb3_sel1", 32'(out3), 32'b011);
        sel3 = 2'd2; #1; check("comb3_sel2", 32'(out3), 32'b101);
        check("err3_sel2", 32'(err3), 32'h0);
        sel3 = 2'd3; #1;
        check("comb3_sel3", 32'(out3), 32'h0);
        check("err3_sel3",  32'(err3), 32'h1);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_load_r4",  32'(out4_r), 32'hA);
        check("first_load_chg", 32'(chg4),   32'h1);
        check("err3_r_set",     32'(err3_r), 32'h1);
        check("r3_oor",         32'(out3_r), 32'h0);
        check("chg3_zero",      32'(chg3),   32'h0);

        @(negedge clk);
        check("hold_r4",   32'(out4_r), 32'hA);
        check("hold_chg4", 32'(chg4),   32'h0);

        sel4 = 2'd1;
        #1;
        check("sel1_comb",  32'(out4),   32'hB);
        check("sel1_r_old", 32'(out4_r), 32'hA);
        @(negedge clk);
        check("sel1_r4",   32'(out4_r), 32'hB);
        check("sel1_chg4", 32'(chg4),   32'h1);
        @(negedge clk);
        check("sel1_hold_chg", 32'(chg4), 32'h0);

        // data change with select held
        ids4 = 16'hDC7A;
        sel3 = 2'd1;
        #1;
        check("id_chg_comb", 32'(out4), 32'h7);
        @(negedge clk);
        check("id_chg_r4",   32'(out4_r), 32'h7);
        check("id_chg_chg4", 32'(chg4),   32'h1);
        check("sel3_r",      32'(out3_r), 32'b011);
        check("sel3_err_r",  32'(err3_r), 32'h0);
        check("sel3_chg",    32'(chg3),   32'h1);

        // mid-cycle reset
        @(negedge clk);
        check("pre_rst_chg4", 32'(chg4), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_r4",   32'(out4_r), 32'h0);
        check("midrst_chg4", 32'(chg4),   32'h0);
        check("midrst_comb", 32'(out4),   32'h7);
        check("midrst_r3",   32'(out3_r), 32'h0);
        @(negedge clk);
        check("rst_held_r4", 32'(out4_r), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reload_r4",   32'(out4_r), 32'h7);
        check("reload_chg4", 32'(chg4),   32'h1);
        check("reload_r3",   32'(out3_r), 32'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_id_arbiter.md
MUX_ID_ARBITER -- requirements
Module: mux_id_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of masters and width of each ID segment; legal range 2..16.
REQ-002 Localparam SEL_W = max(1, clog2(NUM_MASTERS)), width of the select input.
REQ-003 clk_i  input  1  single clock; all registers rise-edge triggered.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 Master_ID_Selected_i  input  NUM_MASTERS*NUM_MASTERS  flattened ID vector; segment k occupies bits [k*NUM_MASTERS +: NUM_MASTERS].
REQ-006 number_select_i  input  SEL_W  index of the segment to route.
REQ-007 Master_ID_Selected_o  output  NUM_MASTERS  combinational selected segment.
REQ-008 Master_ID_Selected_r_o  output  NUM_MASTERS  registered copy of Master_ID_Selected_o.
REQ-009 select_err_o  output  1  combinational; high when number_select_i >= NUM_MASTERS.
REQ-010 select_err_r_o  output  1  registered copy of select_err_o.
REQ-011 sel_changed_o  output  1  registered; one-cycle pulse when the registered output value changes.

Function
REQ-012 Master_ID_Selected_o SHALL equal segment number_select_i of Master_ID_Selected_i with zero latency (pure combinational path, no clock dependency).
REQ-013 Segment 0 SHALL be the least-significant NUM_MASTERS bits.
REQ-014 Select values >= NUM_MASTERS (possible only when NUM_MASTERS is not a power of two) SHALL drive Master_ID_Selected_o to all zeros and assert select_err_o.
REQ-015 Wider values driven onto number_select_i are truncated to SEL_W bits by the port; the truncated value is the only one the block interprets.
REQ-016 Master_ID_Selected_r_o and select_err_r_o SHALL capture their combinational counterparts on every clk_i rising edge (latency 1 cycle).
REQ-017 sel_changed_o SHALL be high for exactly the cycle after a clock edge in which the newly captured Master_ID_Selected_r_o differs from its previous value; otherwise low.
REQ-018 Changes in Master_ID_Selected_i alone (same select) SHALL propagate identically to select changes on both the combinational and registered paths.
REQ-019 No X propagation SHALL occur from unselected segments.

Reset
REQ-020 While reset_i is high, Master_ID_Selected_r_o = 0, select_err_r_o = 0, sel_changed_o = 0, asynchronously.
REQ-021 Reset SHALL NOT affect the combinational outputs Master_ID_Selected_o and select_err_o.
REQ-022 The first rising edge after reset_i deasserts SHALL load the registers normally; sel_changed_o pulses if the loaded value is nonzero.

Structure
REQ-023 A shared package SHALL hold the default NUM_MASTERS and a clog2-based SEL_W helper function, reused by the interconnect arbiters.
REQ-024 One sub-module, id_segment_mux (combinational segment select plus range check), SHALL be instantiated by mux_id_arbiter, which adds the register stage.

Verification
REQ-025 NUM_MASTERS=4, Master_ID_Selected_i=16'hDCBA, select 0/1/2/3 -> Master_ID_Selected_o = 1010/1011/1100/1101, select_err_o=0, each within the same delta time.
REQ-026 NUM_MASTERS=4, drive 16 onto select (truncates to 0) -> output 1010, select_err_o=0.
REQ-027 NUM_MASTERS=3, Master_ID_Selected_i=9'b101_011_110, select 3 -> output 000, select_err_o=1, select_err_r_o=1 one cycle later.
REQ-028 Clocked run, select 0 then 1 with 16'hDCBA -> Master_ID_Selected_r_o follows one edge later, sel_changed_o single-cycle pulse per change, none when the select is held.
REQ-029 Assert reset_i mid-run between clock edges -> registered outputs go to 0 immediately, combinational output unchanged; after release, first edge reloads the current segment.
